// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider: toggle or pulse output from the system clock.
// New divisors wait in a shadow register and take effect only at a wrap or restart.
module clkdiv_prog #(
    parameter int unsigned        WIDTH       = 32,
    parameter logic [WIDTH-1:0]   DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             restart,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    output logic             clk_div,
    output logic             tick,
    output logic             pending,
    output logic             load_err
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pend;

    logic wrap;
    logic boundary;
    logic load_ok;
    logic load_bad;

    // cnt never passes div_act-1, because a smaller divisor only lands on a boundary.
    assign wrap     = en && (cnt == div_act - 1'b1);
    assign boundary = restart || wrap;
    assign load_ok  = div_load && (div_val != '0);
    assign load_bad = div_load && (div_val == '0);

    assign pending = pend;

    // NOTE: every register here uses non-blocking assignments, so all next-state
    // terms see the pre-edge values of cnt, div_act and pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_act  <= DEFAULT_DIV;
            div_pend <= '0;
            pend     <= 1'b0;
            clk_div  <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_bad;

            if (restart) begin
                cnt     <= '0;
                clk_div <= 1'b0;
                tick    <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_div <= mode ? 1'b1 : ~clk_div;
            end else begin
                if (en) begin
                    cnt <= cnt + 1'b1;
                end
                tick <= 1'b0;
                if (mode) begin
                    clk_div <= 1'b0;
                end
            end

            // The boundary consumes the value pending before this edge; a load on
            // the same edge becomes the next pending value.
            if (boundary && pend) begin
                div_act <= div_pend;
            end

            if (load_ok) begin
                div_pend <= div_val;
                pend     <= 1'b1;
            end else if (boundary) begin
                pend     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog with an 8-bit divisor and a default divisor of 4.
// Inputs change 1 ns after each rising edge; outputs are sampled at that point too.
module tb_clkdiv_prog;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             restart;
    logic             div_load;
    logic [WIDTH-1:0] div_val;
    logic             clk_div;
    logic             tick;
    logic             pending;
    logic             load_err;

    int checks = 0;
    int errors = 0;

    clkdiv_prog #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (8'd4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .restart  (restart),
        .div_load (div_load),
        .div_val  (div_val),
        .clk_div  (clk_div),
        .tick     (tick),
        .pending  (pending),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n edges; bit n-1 of cb/tb is the expectation after the first edge.
    task automatic run(input int n, input logic [15:0] cb, input logic [15:0] tb_bits,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_clk_div[%0d]", tag, i), clk_div, cb[n-1-i]);
            chk($sformatf("%s_tick[%0d]", tag, i), tick, tb_bits[n-1-i]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        mode     = 1'b0;
        restart  = 1'b0;
        div_load = 1'b0;
        div_val  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_div", clk_div, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        rst_n = 1'b1;

        // Default divisor 4, toggle mode: half-period 4, tick every 4 cycles.
        run(8, 16'b0001_1110, 16'b0001_0001, "default");
        chk("default_load_err", load_err, 1'b0);

        // Load 3 in pulse mode, apply it with a restart.
        mode = 1'b1; div_load = 1'b1; div_val = 8'd3;
        run(1, 16'b0, 16'b0, "pulse_load");
        chk("pulse_load_pending", pending, 1'b1);
        div_load = 1'b0; restart = 1'b1;
        run(1, 16'b0, 16'b0, "pulse_restart");
        chk("pulse_restart_pending", pending, 1'b0);
        restart = 1'b0;
        run(6, 16'b001001, 16'b001001, "pulse3");

        // Divisor 1 in pulse mode: output sticks high after the next wrap.
        div_load = 1'b1; div_val = 8'd1;
        run(1, 16'b0, 16'b0, "div1_load");
        chk("div1_pending", pending, 1'b1);
        div_load = 1'b0;
        run(5, 16'b01111, 16'b01111, "div1");
        chk("div1_pending_clear", pending, 1'b0);

        // Switch to toggle mode with divisor 6 via two restarts.
        mode = 1'b0; div_load = 1'b1; div_val = 8'd6; restart = 1'b1;
        run(1, 16'b0, 16'b0, "div6_load");
        chk("div6_pending", pending, 1'b1);
        div_load = 1'b0;
        run(1, 16'b0, 16'b0, "div6_restart");
        chk("div6_pending_clear", pending, 1'b0);
        restart = 1'b0;

        // Reload 2 at cnt=1; it waits for the wrap at cnt=5.
        run(1, 16'b0, 16'b0, "reload_cnt0");
        div_load = 1'b1; div_val = 8'd2;
        run(1, 16'b0, 16'b0, "reload_load");
        chk("reload_pending", pending, 1'b1);
        div_load = 1'b0;
        run(3, 16'b000, 16'b000, "reload_wait");
        chk("reload_pending_hold", pending, 1'b1);
        run(1, 16'b1, 16'b1, "reload_wrap");
        chk("reload_pending_clear", pending, 1'b0);
        run(4, 16'b1001, 16'b0101, "half2");

        // Two loads (5 then 7) while held; 7 is the one applied.
        en = 1'b0; div_load = 1'b1; div_val = 8'd5;
        run(1, 16'b1, 16'b0, "dbl_load5");
        div_val = 8'd7;
        run(1, 16'b1, 16'b0, "dbl_load7");
        div_load = 1'b0; en = 1'b1;
        run(9, 16'b1_0000_0001, 16'b0_1000_0001, "div7");

        // Zero load: one-cycle error strobe, divisor and pending untouched.
        div_load = 1'b1; div_val = 8'd0;
        run(1, 16'b1, 16'b0, "err_load");
        chk("err_load_err", load_err, 1'b1);
        chk("err_pending", pending, 1'b0);
        div_load = 1'b0;
        run(1, 16'b1, 16'b0, "err_after");
        chk("err_load_err_clear", load_err, 1'b0);
        run(5, 16'b11110, 16'b00001, "err_div7");

        // Enable low for 10 cycles mid-period with clk_div high.
        run(7, 16'b000_0001, 16'b000_0001, "pre_hold");
        run(2, 16'b11, 16'b00, "pre_hold2");
        en = 1'b0;
        run(10, 16'b11_1111_1111, 16'b0, "hold");
        en = 1'b1;
        run(5, 16'b11110, 16'b00001, "resume");

        // Restart with 3 pending while clk_div is high.
        run(7, 16'b000_0001, 16'b000_0001, "pre_restart");
        div_load = 1'b1; div_val = 8'd3;
        run(1, 16'b1, 16'b0, "rs_load");
        chk("rs_pending", pending, 1'b1);
        div_load = 1'b0; restart = 1'b1;
        run(1, 16'b0, 16'b0, "rs_restart");
        chk("rs_pending_clear", pending, 1'b0);
        restart = 1'b0;
        run(3, 16'b001, 16'b001, "rs_div3");

        // Asynchronous reset between edges while clk_div is high and a load pends.
        div_load = 1'b1; div_val = 8'd5;
        run(1, 16'b1, 16'b0, "ar_pre");
        chk("ar_pre_pending", pending, 1'b1);
        div_load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clk_div", clk_div, 1'b0);
        chk("ar_tick", tick, 1'b0);
        chk("ar_pending", pending, 1'b0);
        chk("ar_load_err", load_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8, 16'b0001_1110, 16'b0001_0001, "ar_default");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Runtime-programmable clock divider and tick generator that produces a toggle clock or single-cycle pulse train from the system clock. The divisor is loaded through a shadow register and applied glitch-free at the next period boundary. It also provides an enable, a synchronous restart and a load-error strobe. It sits between the board clock and the counter/display logic, and replaces fixed-frequency dividers wherever the rate must change without resynthesis.

## Interface

- WIDTH, 32: width of the divisor and internal counter.
- DEFAULT_DIV, 25_000_000: divisor loaded at reset. Must be ≥1 and < 2^WIDTH. At 50 MHz this gives 1 Hz in toggle mode.

- clk  in  1  system clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, the counter holds.
- mode  in  1  0 = toggle (50 % duty, period 2·div), 1 = pulse (clk_div high 1 cycle every div cycles).
- restart  in  1  synchronous restart strobe.
- div_load  in  1  one-cycle strobe that captures div_val.
- div_val  in  WIDTH  requested divisor (half-period in mode 0, period in mode 1).
- clk_div  out  1  divided output, registered.
- tick  out  1  one-cycle strobe at every counter wrap, registered.
- pending  out  1  a loaded divisor is waiting for the next boundary.
- load_err  out  1  one-cycle strobe: div_load was issued with div_val = 0.

## Operation

- State: cnt[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend, plus output registers.
- Reset (rst_n low, asynchronous): cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend=0, clk_div=0, tick=0, load_err=0. All outputs are 0 while rst_n is low.
- Wrap condition: en=1 and cnt == div_act−1.
- Per cycle, restart=0, en=1:
  - Wrap: cnt←0, tick←1. Mode 0: clk_div←~clk_div. Mode 1: clk_div←1. If pend: div_act←div_pend, pend←0.
  - No wrap: cnt←cnt+1, tick←0. Mode 0: clk_div holds. Mode 1: clk_div←0.
- en=0: cnt, div_act and pend hold; tick←0. Mode 0: clk_div holds. Mode 1: clk_div←0.
- restart=1 (highest priority, regardless of en): cnt←0, clk_div←0, tick←0. If pend: div_act←div_pend, pend←0.
- Load handling:
  - div_load=1 with div_val≠0: div_pend←div_val, pend←1. A newer load overwrites an older pending value.
  - div_load=1 with div_val=0: load_err←1 for one cycle. div_pend and pend are unchanged.
  - load_err is 0 in every other cycle.
- Load in the same cycle as a wrap or restart: the boundary applies the previously pending value, if any. The new value becomes pending, pend=1 afterward.
- Load with no prior pending at a boundary: the new value is not applied until the following boundary.
- div_act=1:
  - Mode 0: clk_div toggles every enabled cycle.
  - Mode 1: clk_div stays high continuously while en=1.
- Mode switch takes effect on the same edge it is sampled. Switching 1→0 leaves clk_div at its current value, then follows toggle rules.
- cnt never exceeds div_act−1. After a divisor reduction, the old period completes first, so there is no overflow case.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Mode 0: output period is 2·div_act cycles. First toggle after reset occurs on the div_act-th enabled edge.
- Mode 1: output period is div_act cycles. clk_div and tick are coincident, each one cycle high.
- tick asserts one cycle after the edge where cnt == div_act−1 is sampled, i.e., concurrent with the clk_div change.
- Divisor change latency: applied at the first wrap or restart after the load edge. The new period starts on the following cycle.
- pending rises the cycle after div_load and falls the cycle after the applying boundary.
- Deasserting rst_n mid-period restarts from the reset state. Counting begins on the first rising edge with rst_n high.

## Test plan

- Reset/default: DEFAULT_DIV=4, mode 0, en=1 → clk_div toggles every 4 cycles (period 8); tick pulses every 4 cycles; load_err=0.
- Pulse mode: div=3, mode 1 → clk_div and tick high one cycle in every 3, low otherwise. Then div_load div_val=1 → clk_div stuck high after the next wrap.
- Runtime reload: div=6, div_load div_val=2 at cnt=1 → pending=1 until the wrap at cnt=5, then half-period 2. Two loads (5, then 7) before the wrap → 7 is applied.
- Error path: div_load with div_val=0 → load_err high exactly one cycle; divisor and pending unchanged.
- Enable/restart: en low for 10 cycles mid-period → cnt and clk_div frozen, tick=0. restart with pending 3 → cnt=0, clk_div=0, div_act=3 next cycle.
- Async reset mid-operation: drop rst_n between edges → all outputs 0 immediately. Release → default divisor behaviour resumes.
